// File: rtl/if_stage_pkg.sv
// Shared IF-stage definitions: fetch FSM encoding, IF/ID layout, bubble helper.
// Imported by the fetch stage and by downstream decode/control logic.
package if_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
    localparam int          INSTR_HI     = 63;
    localparam int          PC4_LO       = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } if_id_t;

    function automatic if_id_t bubble(input logic [31:0] nop);
        if_id_t b;
        b.instr = nop;
        b.pc4   = 32'h0000_0000;
        return b;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bundle; memory may answer in the request cycle.
// Request and address are held by the master until ready is seen.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: bubble beats load, otherwise holds; one-cycle latency.
// No backpressure of its own; the caller decides load/bubble/hold each cycle.
module if_stage_if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   load,
    input  logic   bubble_en,
    input  if_id_t d,
    output if_id_t q,
    output logic   vld
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q   <= bubble(NOP_WORD);
            vld <= 1'b0;
        end else if (bubble_en) begin
            q   <= bubble(NOP_WORD);
            vld <= 1'b0;
        end else if (load) begin
            q   <= d;
            vld <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// MIPS fetch stage: PC, variable-latency imem handshake, IF/ID load; 1 instr/cycle at zero wait.
// Stall parks a returned word in a hold buffer with no request; redirect during a wait drains first.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    if_stage_if.master  imem,
    output logic [63:0] IF_ID_out,
    output logic        IF_ID_valid,
    output logic [31:0] pc
);

    fetch_state_t state, state_nxt;
    if_id_t       hold_q, hold_nxt;
    logic [31:0]  pend_q, pend_nxt;
    logic [31:0]  pc_nxt;
    logic [31:0]  pc_plus4;
    logic [31:0]  tgt_pc;
    logic         id_ld, id_bub;
    if_id_t       id_d, id_q;
    logic         unused_rpc_bits;

    assign pc_plus4        = pc + 32'd4;
    assign tgt_pc          = {redirect_pc[31:2], 2'b00};
    assign unused_rpc_bits = ^redirect_pc[1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            pc     <= PC_RESET;
            hold_q <= bubble(NOP_WORD);
            pend_q <= 32'h0000_0000;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            hold_q <= hold_nxt;
            pend_q <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        hold_nxt  = hold_q;
        pend_nxt  = pend_q;
        id_ld     = 1'b0;
        id_bub    = flush;
        id_d      = '{instr: imem.imem_rdata, pc4: pc_plus4};
        case (state)
            ST_IDLE: begin
                state_nxt = ST_FETCH;
                if (redirect) begin
                    pc_nxt = tgt_pc;
                    id_bub = 1'b1;
                end
            end
            ST_FETCH: begin
                if (imem.imem_ready) begin
                    if (redirect) begin
                        pc_nxt = tgt_pc;
                        id_bub = 1'b1;
                    end else if (stall) begin
                        hold_nxt  = '{instr: imem.imem_rdata, pc4: pc_plus4};
                        state_nxt = ST_HOLD;
                    end else begin
                        id_ld  = 1'b1;
                        pc_nxt = pc_plus4;
                    end
                end else begin
                    // An issued request cannot be withdrawn, so park the target.
                    if (redirect) begin
                        pend_nxt  = tgt_pc;
                        state_nxt = ST_DRAIN;
                    end
                    if (!stall) id_bub = 1'b1;
                end
            end
            ST_HOLD: begin
                // pc is not advanced while holding, so it already equals the buffered pc.
                if (redirect) begin
                    pc_nxt    = tgt_pc;
                    id_bub    = 1'b1;
                    state_nxt = ST_FETCH;
                end else if (flush) begin
                    state_nxt = ST_FETCH;
                end else if (!stall) begin
                    id_ld     = 1'b1;
                    id_d      = hold_q;
                    pc_nxt    = pc_plus4;
                    state_nxt = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (redirect) pend_nxt = tgt_pc;
                if (imem.imem_ready) begin
                    pc_nxt    = pend_nxt;
                    state_nxt = ST_FETCH;
                end
                if (!stall) id_bub = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign imem.imem_req  = (state == ST_FETCH) || (state == ST_DRAIN);
    assign imem.imem_addr = pc;

    if_stage_if_id_reg #(.NOP_WORD(NOP_WORD)) u_if_id (
        .clock     (clock),
        .reset     (reset),
        .load      (id_ld),
        .bubble_en (id_bub),
        .d         (id_d),
        .q         (id_q),
        .vld       (IF_ID_valid)
    );

    assign IF_ID_out = id_q[INSTR_HI:PC4_LO];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: streaming, wait states, stall/hold, drain redirect, flush, wrap, reset.
module tb_if_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        mem_ready = 1'b1;

    logic [63:0] if_id_out, w_if_id_out;
    logic        if_id_valid, w_if_id_valid;
    logic [31:0] pc, w_pc;

    int n_chk = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    if_stage_if mif ();
    if_stage_if wif ();

    assign mif.imem_ready = mem_ready;
    assign mif.imem_rdata = 32'hA000_0000 | mif.imem_addr;
    assign wif.imem_ready = 1'b1;
    assign wif.imem_rdata = 32'h5500_0000 ^ wif.imem_addr;

    if_stage u_dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (mif),
        .IF_ID_out   (if_id_out),
        .IF_ID_valid (if_id_valid),
        .pc          (pc)
    );

    if_stage #(.PC_RESET(32'hFFFF_FFFC)) u_wrap (
        .clock       (clock),
        .reset       (reset),
        .stall       (1'b0),
        .flush       (1'b0),
        .redirect    (1'b0),
        .redirect_pc (32'h0),
        .imem        (wif),
        .IF_ID_out   (w_if_id_out),
        .IF_ID_valid (w_if_id_valid),
        .pc          (w_pc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_req",   mif.imem_req, 0);
        chk("rst_pc",    pc, 32'h0);
        chk("rst_ifid",  if_id_out, 64'h0);
        chk("rst_valid", if_id_valid, 0);
        chk("rst_wpc",   w_pc, 32'hFFFF_FFFC);

        @(negedge clock);
        reset = 1'b1;

        tick();
        chk("idle_req",   mif.imem_req, 1);
        chk("idle_addr",  mif.imem_addr, 32'h0);
        chk("idle_valid", if_id_valid, 0);
        chk("wrap_addr0", wif.imem_addr, 32'hFFFF_FFFC);

        tick();
        chk("s0_addr",  mif.imem_addr, 32'h4);
        chk("s0_ifid",  if_id_out, 64'hA000_0000_0000_0004);
        chk("s0_valid", if_id_valid, 1);
        chk("wrap_addr1", wif.imem_addr, 32'h0);
        chk("wrap_ifid",  w_if_id_out, 64'hAAFF_FFFC_0000_0000);
        chk("wrap_valid", w_if_id_valid, 1);

        for (int i = 1; i < 4; i++) begin
            tick();
            chk("stream_addr", mif.imem_addr, 32'(4 * (i + 1)));
            chk("stream_pc4",  if_id_out[31:0], 32'(4 * (i + 1)));
            chk("stream_instr", if_id_out[63:32], 32'hA000_0000 | 32'(4 * i));
        end

        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("wait_req",   mif.imem_req, 1);
            chk("wait_addr",  mif.imem_addr, 32'h10);
            chk("wait_valid", if_id_valid, 0);
        end
        mem_ready = 1'b1;
        tick();
        chk("late_ifid",  if_id_out, 64'hA000_0010_0000_0014);
        chk("late_valid", if_id_valid, 1);
        chk("late_addr",  mif.imem_addr, 32'h14);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_req",  mif.imem_req, 0);
            chk("hold_ifid", if_id_out, 64'hA000_0010_0000_0014);
            chk("hold_pc",   pc, 32'h14);
        end
        stall = 1'b0;
        tick();
        chk("rel_ifid",  if_id_out, 64'hA000_0014_0000_0018);
        chk("rel_valid", if_id_valid, 1);
        chk("rel_pc",    pc, 32'h18);
        tick();
        chk("rel_next",  if_id_out, 64'hA000_0018_0000_001C);
        tick();
        chk("pre_redir_addr", mif.imem_addr, 32'h20);

        mem_ready   = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0403;
        tick();
        chk("drain_req",   mif.imem_req, 1);
        chk("drain_addr",  mif.imem_addr, 32'h20);
        chk("drain_valid", if_id_valid, 0);
        redirect = 1'b0;
        tick();
        chk("drain_addr2", mif.imem_addr, 32'h20);
        mem_ready = 1'b1;
        tick();
        chk("redir_addr",  mif.imem_addr, 32'h400);
        chk("redir_valid", if_id_valid, 0);
        tick();
        chk("redir_ifid",  if_id_out, 64'hA000_0400_0000_0404);
        chk("redir_vld1",  if_id_valid, 1);

        stall = 1'b1;
        flush = 1'b1;
        tick();
        chk("fs_ifid",  if_id_out, 64'h0);
        chk("fs_valid", if_id_valid, 0);
        chk("fs_pc",    pc, 32'h404);
        chk("fs_req",   mif.imem_req, 0);
        tick();
        chk("fhold_pc",  pc, 32'h404);
        chk("fhold_req", mif.imem_req, 1);
        stall = 1'b0;
        flush = 1'b0;
        tick();
        chk("refetch_ifid", if_id_out, 64'hA000_0404_0000_0408);
        chk("refetch_pc",   pc, 32'h408);

        mem_ready = 1'b0;
        tick();
        chk("mid_req", mif.imem_req, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_req",   mif.imem_req, 0);
        chk("arst_pc",    pc, 32'h0);
        chk("arst_valid", if_id_valid, 0);
        chk("arst_ifid",  if_id_out, 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
